// File: rtl/line_split_sequencer.sv
// Splits one byte-addressed request into line-aligned transactions,
// emitted in ascending order, with one completion pulse per request.
module line_split_sequencer #(
  parameter int ADDR_WIDTH = 64,
  parameter int LINE_BYTES = 128,
  parameter int ID_WIDTH   = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic [ADDR_WIDTH-1:0]         req_addr,
  input  logic [31:0]                   req_size,
  input  logic [ID_WIDTH-1:0]           req_id,
  output logic                          txn_valid,
  input  logic                          txn_ready,
  output logic [ADDR_WIDTH-1:0]         txn_addr,
  output logic [$clog2(LINE_BYTES)-1:0] txn_offset,
  output logic [$clog2(LINE_BYTES):0]   txn_count,
  output logic                          txn_first,
  output logic                          txn_last,
  output logic [ID_WIDTH-1:0]           txn_id,
  output logic                          cmpl_valid,
  output logic [ID_WIDTH-1:0]           cmpl_id
);

  localparam int OW = $clog2(LINE_BYTES);

  typedef enum logic {
    IDLE,
    ISSUE
  } state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] line_addr;
  logic [OW-1:0]         off;
  logic [32:0]           remaining;
  logic                  first;
  logic [ID_WIDTH-1:0]   id;

  logic                  issue;
  logic [OW-1:0]         cur_off;
  logic [OW:0]           avail;
  logic [OW:0]           count;
  logic                  last;

  assign issue   = (state == ISSUE);
  assign cur_off = first ? off : '0;
  assign avail   = (OW+1)'(LINE_BYTES) - {1'b0, cur_off};

  always_comb begin
    count = avail;
    if (remaining < 33'(avail))
      count = remaining[OW:0];
  end

  assign last = (remaining == 33'(count));

  assign req_ready  = (state == IDLE) && !rst;
  assign txn_valid  = issue;
  // Idle outputs read as zero so reset and idle look identical downstream
  assign txn_addr   = issue ? line_addr : '0;
  assign txn_offset = issue ? cur_off : '0;
  assign txn_count  = issue ? count : '0;
  assign txn_first  = issue && first;
  assign txn_last   = issue && last;
  assign txn_id     = issue ? id : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      line_addr  <= '0;
      off        <= '0;
      remaining  <= '0;
      first      <= 1'b0;
      id         <= '0;
      cmpl_valid <= 1'b0;
      cmpl_id    <= '0;
    end else begin
      cmpl_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (req_valid) begin
            id        <= req_id;
            line_addr <= {req_addr[ADDR_WIDTH-1:OW], {OW{1'b0}}};
            off       <= req_addr[OW-1:0];
            remaining <= {1'b0, req_size};
            if (req_size == 32'd0) begin
              cmpl_valid <= 1'b1;
              cmpl_id    <= req_id;
            end else begin
              state <= ISSUE;
              first <= 1'b1;
            end
          end
        end
        ISSUE: begin
          if (txn_ready) begin
            remaining <= remaining - 33'(count);
            line_addr <= line_addr + ADDR_WIDTH'(LINE_BYTES);
            first     <= 1'b0;
            if (last) begin
              state      <= IDLE;
              cmpl_valid <= 1'b1;
              cmpl_id    <= id;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_line_split_sequencer.sv
// Scoreboard bench for line_split_sequencer: expected lines and
// completions are queued at request time and popped as the DUT emits.
module tb_line_split_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [63:0] req_addr = '0;
  logic [31:0] req_size = '0;
  logic [7:0]  req_id = '0;
  logic        txn_valid;
  logic        txn_ready = 1'b1;
  logic [63:0] txn_addr;
  logic [6:0]  txn_offset;
  logic [7:0]  txn_count;
  logic        txn_first;
  logic        txn_last;
  logic [7:0]  txn_id;
  logic        cmpl_valid;
  logic [7:0]  cmpl_id;

  line_split_sequencer #(
    .ADDR_WIDTH(64),
    .LINE_BYTES(128),
    .ID_WIDTH(8)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_size(req_size), .req_id(req_id),
    .txn_valid(txn_valid), .txn_ready(txn_ready),
    .txn_addr(txn_addr), .txn_offset(txn_offset),
    .txn_count(txn_count), .txn_first(txn_first),
    .txn_last(txn_last), .txn_id(txn_id),
    .cmpl_valid(cmpl_valid), .cmpl_id(cmpl_id)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [63:0] addr;
    logic [6:0]  off;
    logic [7:0]  cnt;
    logic        first;
    logic        last;
    logic [7:0]  id;
  } txn_t;

  txn_t       txq[$];
  logic [7:0] cq[$];
  int         checks = 0;
  int         errors = 0;
  logic       bp = 1'b0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  always @(posedge clk) begin
    #1;
    txn_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Monitor: pops scoreboard on each handshake / completion
  logic        stall = 1'b0;
  txn_t        snap;
  always @(negedge clk) begin
    if (rst) begin
      stall = 1'b0;
    end else begin
      if (stall) begin
        chk("stall_valid", txn_valid, 1'b1);
        chk("stall_hold", {txn_addr, txn_offset, txn_count, txn_first,
                           txn_last, txn_id}, snap);
      end
      if (txn_valid && txn_ready) begin
        if (txq.size() == 0) begin
          chk("txn_extra", 1'b1, 1'b0);
        end else begin
          txn_t e;
          e = txq.pop_front();
          chk("txn_addr", txn_addr, e.addr);
          chk("txn_off", txn_offset, e.off);
          chk("txn_cnt", txn_count, e.cnt);
          chk("txn_first", txn_first, e.first);
          chk("txn_last", txn_last, e.last);
          chk("txn_id", txn_id, e.id);
        end
      end
      if (cmpl_valid) begin
        if (cq.size() == 0) chk("cmpl_extra", 1'b1, 1'b0);
        else chk("cmpl_id", cmpl_id, cq.pop_front());
      end
      stall = txn_valid && !txn_ready;
      snap  = {txn_addr, txn_offset, txn_count, txn_first, txn_last, txn_id};
    end
  end

  // Queue expected lines; abort keeps only the first line and no completion
  task automatic expect_req(input logic [63:0] a, input logic [31:0] sz,
                            input logic [7:0] rid, input bit abort);
    logic [63:0] la;
    logic [32:0] rem;
    int          o;
    int          c;
    bit          f;
    txn_t        t;
    la  = {a[63:7], 7'd0};
    rem = {1'b0, sz};
    f   = 1'b1;
    while (rem != 0) begin
      o = f ? int'(a[6:0]) : 0;
      c = (rem < 33'(128 - o)) ? int'(rem) : 128 - o;
      t.addr  = la;
      t.off   = 7'(o);
      t.cnt   = 8'(c);
      t.first = f;
      t.last  = (rem == 33'(c));
      t.id    = rid;
      txq.push_back(t);
      rem = rem - 33'(c);
      la  = la + 64'd128;
      f   = 1'b0;
      if (abort) rem = 0;
    end
    if (!abort) cq.push_back(rid);
  endtask

  task automatic send(input logic [63:0] a, input logic [31:0] sz,
                      input logic [7:0] rid, input bit abort);
    int n;
    n = 0;
    while (!req_ready && n < 500) begin
      @(posedge clk);
      #2;
      n++;
    end
    if (!req_ready) chk("req_ready_timeout", 1'b0, 1'b1);
    expect_req(a, sz, rid, abort);
    req_valid = 1'b1;
    req_addr  = a;
    req_size  = sz;
    req_id    = rid;
    @(posedge clk);
    #2;
    req_valid = 1'b0;
    if (sz == 0) begin
      chk("zs_cmpl_n1", cmpl_valid, 1'b1);
      chk("zs_no_txn", txn_valid, 1'b0);
      chk("zs_ready", req_ready, 1'b1);
    end else begin
      chk("first_lat", txn_valid, 1'b1);
      chk("busy_ready", req_ready, 1'b0);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((txq.size() != 0 || cq.size() != 0) && n < 2000) begin
      @(posedge clk);
      n++;
    end
    chk("drain", 32'(txq.size() + cq.size()), 32'd0);
    @(posedge clk);
    #2;
  endtask

  task automatic chk_idle_outs(input string tag);
    chk(tag, {txn_valid, cmpl_valid, txn_addr, txn_offset, txn_count,
              txn_first, txn_last, txn_id, cmpl_id}, '0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #2;
    chk_idle_outs("rst_outs");
    chk("rst_ready", req_ready, 1'b0);
    rst = 1'b0;
    #1;
    chk("post_rst_ready", req_ready, 1'b1);

    send(64'h1000, 32'd128, 8'd3, 1'b0);
    drain();
    send(64'h107C, 32'd8, 8'd4, 1'b0);
    drain();

    bp = 1'b1;
    send(64'h10, 32'd300, 8'd5, 1'b0);
    drain();
    bp = 1'b0;

    send(64'hFFFF_FFFF_FFFF_FFC0, 32'd128, 8'd6, 1'b0);
    drain();

    send(64'h55, 32'd0, 8'd7, 1'b0);
    send(64'h56, 32'd0, 8'd8, 1'b0);
    drain();

    // Abandon a 3-line request after its first line
    send(64'h2000, 32'd300, 8'd9, 1'b1);
    begin
      int n;
      n = 0;
      while (txq.size() != 0 && n < 100) begin
        @(negedge clk);
        #1;
        n++;
      end
      chk("abort_first_seen", 32'(txq.size()), 32'd0);
    end
    rst = 1'b1;
    @(posedge clk);
    #2;
    chk_idle_outs("midrst_outs");
    chk("midrst_ready", req_ready, 1'b0);
    rst = 1'b0;
    #1;
    chk("midrst_rel_ready", req_ready, 1'b1);
    repeat (3) @(posedge clk);
    #2;
    chk("midrst_no_cmpl", 32'(cq.size()), 32'd0);

    send(64'h3040, 32'd200, 8'd10, 1'b0);
    drain();

    bp = 1'b1;
    for (int i = 0; i < 10; i++) begin
      logic [63:0] a;
      a = {$urandom, $urandom};
      send(a, 32'($urandom_range(0, 600)), 8'(20 + i), 1'b0);
    end
    drain();
    bp = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/line_split_sequencer.md
# line_split_sequencer

Sequences one byte-addressed memory request into LINE_BYTES-aligned line transactions, one per cycle, under valid/ready flow control. It sits between a load/store requester and the coalescer/L1 request port. It applies the same line-alignment arithmetic as the combinational alignment logic: aligned base is the address rounded down to a line, and units = ceil((offset+size)/LINE_BYTES). It then walks the touched lines in ascending order and emits per-line byte offset and byte count, plus a completion pulse per request.

## Interface
- ADDR_WIDTH, 64, byte address width
- LINE_BYTES, 128, line size in bytes; power of two, ≥ 4
- ID_WIDTH, 8, request tag width
- clk  in  1  clock; all logic rising-edge
- rst  in  1  reset; synchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request
- req_addr  in  ADDR_WIDTH  byte address
- req_size  in  32  size in bytes; 0 is legal
- req_id  in  ID_WIDTH  tag
- txn_valid  out  1  line transaction present
- txn_ready  in  1  downstream accepts transaction
- txn_addr  out  ADDR_WIDTH  line-aligned address; low log2(LINE_BYTES) bits are 0
- txn_offset  out  log2(LINE_BYTES)  first byte within line
- txn_count  out  log2(LINE_BYTES)+1  bytes in this line, 1..LINE_BYTES
- txn_first  out  1  first line of request
- txn_last  out  1  last line of request
- txn_id  out  ID_WIDTH  tag of owning request
- cmpl_valid  out  1  one-cycle completion pulse
- cmpl_id  out  ID_WIDTH  tag of completed request

## Operation
- States: IDLE, ISSUE.
- req_ready = (state == IDLE) && !rst. No request is accepted while in ISSUE.
- IDLE, on req_valid && req_ready:
  - Latch id.
  - Set line_addr = addr with low bits cleared, off = addr mod LINE_BYTES, remaining = size. remaining is 33 bits wide, so there is no overflow.
  - If size == 0: no transaction. Pulse cmpl next cycle. Stay IDLE.
  - Else: go to ISSUE with first = 1.
- ISSUE, txn_valid = 1. Outputs are driven from registers:
  - txn_addr = line_addr
  - txn_offset = first ? off : 0
  - txn_count = min(remaining, LINE_BYTES − txn_offset)
  - txn_last = (remaining == txn_count)
- On txn_valid && txn_ready:
  - remaining −= txn_count
  - line_addr += LINE_BYTES, modulo 2^ADDR_WIDTH (wraps to 0, no error)
  - first ← 0
  - If txn_last: go to IDLE and pulse cmpl_valid with cmpl_id = id next cycle.
- Number of transactions per request equals ceil((off + size)/LINE_BYTES).
- While txn_valid = 1 and txn_ready = 0, all txn_* outputs hold stable. txn_valid never drops without a handshake.
- Reset mid-request: the request is abandoned, with no completion pulse and no further transactions. The requester must reissue.

## Timing
- Reset values: state IDLE; txn_valid 0; cmpl_valid 0; txn_addr, txn_offset, txn_count, txn_first, txn_last, txn_id, cmpl_id all 0. req_ready is 0 during rst and 1 in the first cycle after rst deasserts.
- Request handshake at cycle N → txn_valid = 1 at N+1 (first line).
- With txn_ready held high, one line per cycle. A k-line request occupies cycles N+1..N+k.
- Last handshake at cycle M → cmpl_valid = 1 at M+1, and state is IDLE at M+1 (req_ready = 1). Next transaction earliest M+2, so there is one bubble between requests.
- Zero-size handshake at N → cmpl_valid at N+1; req_ready stays 1.
- cmpl_valid is high for exactly one cycle per accepted request that is not cut short by reset.

## Test plan
All cases use LINE_BYTES = 128, ADDR_WIDTH = 64.

1. Aligned single line: addr 0x1000, size 128, id 3 → one txn: 0x1000, off 0, cnt 128, first = last = 1. cmpl_id 3 one cycle later.
2. Small crossing: addr 0x107C, size 8 → txn 0x1000/off 124/cnt 4/first, then txn 0x1080/off 0/cnt 4/last. Total 2 transactions.
3. Multi-line with random txn_ready backpressure: addr 0x10, size 300 → lines 0x0/16/112, 0x80/0/128, 0x100/0/60. Outputs stable during stalls. cmpl exactly once.
4. Address wrap: addr 0xFFFF_FFFF_FFFF_FFC0, size 128 → txn 0xFFFF_FFFF_FFFF_FF80/off 64/cnt 64, then 0x0/off 0/cnt 64/last.
5. Zero size: addr 0x55, size 0, id 7 → no txn_valid. cmpl_valid with id 7 at N+1. Back-to-back zero-size requests each produce one pulse.
6. Reset mid-request: rst asserted after the 1st of 3 lines → txn_valid 0 and cmpl_valid 0 next cycle. All outputs at reset values. Fresh request afterwards sequences correctly.
